// File: rtl/cpu_pkg.sv
// Opcode, ALU function and next-PC select encodings shared by the
// single-cycle MIPS-subset CPU and its decoder.
package cpu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b011011;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b011,
    ALU_AND = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

endpackage

// File: rtl/cpu_control.sv
// Main decoder: opcode (and ALU zero flag for branches) to datapath controls.
module cpu_control
  import cpu_pkg::*;
(
  input  logic [5:0] op,
  input  logic       zero,
  output logic       RegWre,
  output logic       ALUSrcB,
  output logic       InsMemRw,
  output logic       ExtSel,
  output logic       RegDst,
  output logic       PCWre,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic [2:0] ALUOp,
  output logic [1:0] PcSrc
);

  always_comb begin
    RegWre    = 1'b0;
    ALUSrcB   = 1'b0;
    InsMemRw  = 1'b1;
    ExtSel    = 1'b1;
    RegDst    = 1'b0;
    PCWre     = 1'b1;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    ALUOp     = ALU_ADD;
    case (op)
      OP_ADD:  begin RegWre = 1'b1; RegDst = 1'b1; end
      OP_ADDI: begin RegWre = 1'b1; ALUSrcB = 1'b1; end
      OP_SUB:  begin RegWre = 1'b1; RegDst = 1'b1; ALUOp = ALU_SUB; end
      OP_ORI:  begin RegWre = 1'b1; ALUSrcB = 1'b1; ExtSel = 1'b0; ALUOp = ALU_OR; end
      OP_AND:  begin RegWre = 1'b1; RegDst = 1'b1; ALUOp = ALU_AND; end
      OP_OR:   begin RegWre = 1'b1; RegDst = 1'b1; ALUOp = ALU_OR; end
      OP_SLT:  begin RegWre = 1'b1; RegDst = 1'b1; ALUOp = ALU_SLT; end
      OP_SW:   begin ALUSrcB = 1'b1; mWR = 1'b1; end
      OP_LW:   begin RegWre = 1'b1; ALUSrcB = 1'b1; mRD = 1'b1; DBDataSrc = 1'b1; end
      OP_BEQ, OP_BNE: ALUOp = ALU_SUB;
      OP_HALT: PCWre = 1'b0;
      default: ;
    endcase
  end

  // Kept separate from the decode above so zero never appears to feed ALUOp.
  always_comb begin
    PcSrc = PC_NEXT;
    case (op)
      OP_BEQ:  if (zero)  PcSrc = PC_BRANCH;
      OP_BNE:  if (!zero) PcSrc = PC_BRANCH;
      OP_J:    PcSrc = PC_JUMP;
      default: ;
    endcase
  end

endmodule

// File: rtl/single_cycle_cpu.sv
// Single-cycle 32-bit MIPS-subset CPU: PC, instruction ROM, register file,
// extender, ALU and data RAM inline; decode lives in cpu_control.
module single_cycle_cpu
  import cpu_pkg::*;
#(
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 32,
  parameter string IMEM_FILE  = "instr.mem"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pcIn,
  output logic [31:0] pcOut,
  output logic [31:0] PC4,
  output logic [31:0] IDataOut,
  output logic [4:0]  WriteReg,
  output logic [31:0] readData1,
  output logic [31:0] readData2,
  output logic [31:0] writeData,
  output logic [1:0]  PcSrc,
  output logic        RegWre,
  output logic        ALUSrcB,
  output logic        InsMemRw,
  output logic        ExtSel,
  output logic        RegDst,
  output logic        PCWre,
  output logic        mRD,
  output logic        mWR,
  output logic        DBDataSrc,
  output logic [2:0]  ALUOp,
  output logic [31:0] extendResult,
  output logic [31:0] DataOut,
  output logic        zero,
  output logic [31:0] rega,
  output logic [31:0] regb,
  output logic [31:0] ALUreslut
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  logic [31:0] imem   [IMEM_WORDS];
  logic [31:0] dmem_q [DMEM_WORDS];
  logic [31:0] gpr_q  [32];
  logic [31:0] gpr_d  [32];
  logic [31:0] pc_q, pc_d;

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] addr;

  assign pcOut    = pc_q;
  assign PC4      = pc_q + 32'd4;
  assign IDataOut = imem[pc_q[IW+1:2]];

  assign op   = IDataOut[31:26];
  assign rs   = IDataOut[25:21];
  assign rt   = IDataOut[20:16];
  assign rd   = IDataOut[15:11];
  assign imm  = IDataOut[15:0];
  assign addr = IDataOut[25:0];

  cpu_control u_ctrl (
    .op        (op),
    .zero      (zero),
    .RegWre    (RegWre),
    .ALUSrcB   (ALUSrcB),
    .InsMemRw  (InsMemRw),
    .ExtSel    (ExtSel),
    .RegDst    (RegDst),
    .PCWre     (PCWre),
    .mRD       (mRD),
    .mWR       (mWR),
    .DBDataSrc (DBDataSrc),
    .ALUOp     (ALUOp),
    .PcSrc     (PcSrc)
  );

  assign WriteReg     = RegDst ? rd : rt;
  assign readData1    = gpr_q[rs];
  assign readData2    = gpr_q[rt];
  assign extendResult = ExtSel ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  assign rega         = readData1;
  assign regb         = ALUSrcB ? extendResult : readData2;

  always_comb begin
    ALUreslut = 32'd0;
    case (ALUOp)
      ALU_ADD: ALUreslut = rega + regb;
      ALU_SUB: ALUreslut = rega - regb;
      ALU_OR:  ALUreslut = rega | regb;
      ALU_AND: ALUreslut = rega & regb;
      ALU_SLT: ALUreslut = ($signed(rega) < $signed(regb)) ? 32'd1 : 32'd0;
      default: ALUreslut = 32'd0;
    endcase
  end

  assign zero      = (ALUreslut == 32'd0);
  assign DataOut   = mRD ? dmem_q[ALUreslut[DW+1:2]] : 32'd0;
  assign writeData = DBDataSrc ? DataOut : ALUreslut;

  always_comb begin
    pcIn = PC4;
    case (PcSrc)
      PC_BRANCH: pcIn = PC4 + {extendResult[29:0], 2'b00};
      PC_JUMP:   pcIn = {PC4[31:28], addr, 2'b00};
      default:   pcIn = PC4;
    endcase
  end

  assign pc_d = PCWre ? pcIn : pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= 32'd0;
    else       pc_q <= pc_d;
  end

  // $0 is never written, so it reads zero without a read-side mux.
  always_comb begin
    gpr_d = gpr_q;
    if (RegWre && (WriteReg != 5'd0)) gpr_d[WriteReg] = writeData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= 32'd0;
    end else begin
      gpr_q <= gpr_d;
    end
  end

  // Data RAM keeps its contents through reset; writes are only blocked.
  always_ff @(posedge clk) begin
    if (!reset && mWR) dmem_q[ALUreslut[DW+1:2]] <= readData2;
  end

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Bench for single_cycle_cpu: directed program plus random programs checked
// against an instruction-level interpreter.
module tb_single_cycle_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pcIn, pcOut, PC4, IDataOut, readData1, readData2, writeData;
  logic [4:0]  WriteReg;
  logic [1:0]  PcSrc;
  logic        RegWre, ALUSrcB, InsMemRw, ExtSel, RegDst, PCWre, mRD, mWR, DBDataSrc, zero;
  logic [2:0]  ALUOp;
  logic [31:0] extendResult, DataOut, rega, regb, ALUreslut;

  single_cycle_cpu #(.IMEM_WORDS(64), .DMEM_WORDS(32), .IMEM_FILE("")) dut (
    .clk(clk), .reset(reset), .pcIn(pcIn), .pcOut(pcOut), .PC4(PC4), .IDataOut(IDataOut),
    .WriteReg(WriteReg), .readData1(readData1), .readData2(readData2), .writeData(writeData),
    .PcSrc(PcSrc), .RegWre(RegWre), .ALUSrcB(ALUSrcB), .InsMemRw(InsMemRw), .ExtSel(ExtSel),
    .RegDst(RegDst), .PCWre(PCWre), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .ALUOp(ALUOp),
    .extendResult(extendResult), .DataOut(DataOut), .zero(zero), .rega(rega), .regb(regb),
    .ALUreslut(ALUreslut)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] T_ADD = 6'b000000, T_ADDI = 6'b000001, T_SUB = 6'b000010,
                         T_ORI = 6'b010000, T_AND = 6'b010001, T_OR = 6'b010010,
                         T_SLT = 6'b011011, T_SW = 6'b100110, T_LW = 6'b100111,
                         T_BEQ = 6'b110000, T_BNE = 6'b110001, T_J = 6'b111000,
                         T_HALT = 6'b111111, T_UNDEF = 6'b000011;

  int total = 0;
  int bad = 0;

  logic [31:0] prog  [64];
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [32];
  logic [31:0] m_pc;

  logic [31:0] e_pcin, e_wdata, e_maddr, e_mdata;
  logic [4:0]  e_wreg;
  logic [1:0]  e_pcsrc;
  logic        e_we, e_mwr, e_mrd, e_halt;

  function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] a);
    return {op, a};
  endfunction

  // Architectural effect of the instruction at m_pc.
  task automatic model_eval();
    logic [31:0] ins, a, b, sx, zx, pc4, ea;
    logic [4:0]  rs, rt, rd;
    ins = prog[m_pc[7:2]];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    a = m_reg[rs]; b = m_reg[rt];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0000, ins[15:0]};
    ea = a + sx;
    pc4 = m_pc + 32'd4;
    e_pcin = pc4; e_pcsrc = 2'd0; e_we = 1'b0; e_wreg = 5'd0; e_wdata = 32'd0;
    e_mwr = 1'b0; e_mrd = 1'b0; e_maddr = 32'd0; e_mdata = 32'd0; e_halt = 1'b0;
    case (ins[31:26])
      T_ADD:  begin e_we = 1'b1; e_wreg = rd; e_wdata = a + b; end
      T_ADDI: begin e_we = 1'b1; e_wreg = rt; e_wdata = ea; end
      T_SUB:  begin e_we = 1'b1; e_wreg = rd; e_wdata = a - b; end
      T_ORI:  begin e_we = 1'b1; e_wreg = rt; e_wdata = a | zx; end
      T_AND:  begin e_we = 1'b1; e_wreg = rd; e_wdata = a & b; end
      T_OR:   begin e_we = 1'b1; e_wreg = rd; e_wdata = a | b; end
      T_SLT:  begin e_we = 1'b1; e_wreg = rd; e_wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
      T_SW:   begin e_mwr = 1'b1; e_maddr = ea; e_mdata = b; end
      T_LW:   begin e_mrd = 1'b1; e_we = 1'b1; e_wreg = rt; e_maddr = ea; e_wdata = m_mem[ea[6:2]]; end
      T_BEQ:  if (a == b) begin e_pcsrc = 2'd1; e_pcin = pc4 + sx * 4; end
      T_BNE:  if (a != b) begin e_pcsrc = 2'd1; e_pcin = pc4 + sx * 4; end
      T_J:    begin e_pcsrc = 2'd2; e_pcin = {pc4[31:28], ins[25:0], 2'b00}; end
      T_HALT: e_halt = 1'b1;
      default: ;
    endcase
  endtask

  task automatic model_commit();
    if (e_we && e_wreg != 5'd0) m_reg[e_wreg] = e_wdata;
    if (e_mwr) m_mem[e_maddr[6:2]] = e_mdata;
    if (!e_halt) m_pc = e_pcin;
  endtask

  task automatic load_and_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
  endtask

  task automatic build_directed();
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    prog[0]  = enc_i(T_ADDI, 0, 1, 16'd8);
    prog[1]  = enc_i(T_ORI,  0, 2, 16'hFFFF);
    prog[2]  = enc_r(T_ADD,  1, 2, 3);
    prog[3]  = enc_r(T_SUB,  2, 1, 4);
    prog[4]  = enc_r(T_SLT,  1, 2, 5);
    prog[5]  = enc_i(T_SW,   0, 3, 16'd4);
    prog[6]  = enc_i(T_LW,   0, 6, 16'd4);
    prog[7]  = enc_i(T_ADDI, 0, 0, 16'd5);
    prog[8]  = enc_i(T_BEQ,  1, 1, 16'd2);
    prog[9]  = enc_i(T_ADDI, 0, 7, 16'd1);
    prog[10] = enc_i(T_ADDI, 0, 7, 16'd2);
    prog[11] = enc_i(T_BNE,  1, 1, 16'd5);
    prog[12] = enc_j(T_J, 26'h10);
    prog[13] = enc_i(T_ADDI, 0, 7, 16'd3);
    prog[14] = enc_i(T_SW,   0, 7, 16'd0);
    prog[15] = enc_i(T_ADDI, 0, 7, 16'd4);
    prog[16] = enc_i(T_HALT, 0, 6, 16'd0);
  endtask

  task automatic test_reset();
    build_directed();
    #1 reset = 1'b1;
    for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];
    #1;
    total++; if (pcOut !== 32'd0) begin bad++; $display("FAIL reset_pc: got %h want 0", pcOut); end
    total++; if (IDataOut !== prog[0]) begin bad++; $display("FAIL reset_instr: got %h want %h", IDataOut, prog[0]); end
    total++; if (InsMemRw !== 1'b1) begin bad++; $display("FAIL reset_insmemrw: got %b want 1", InsMemRw); end
    @(negedge clk);
    @(negedge clk);
    total++; if (pcOut !== 32'd0) begin bad++; $display("FAIL reset_pc_hold: got %h want 0", pcOut); end
    total++; if (readData2 !== 32'd0) begin bad++; $display("FAIL reset_no_write: got %h want 0", readData2); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (pcOut !== 32'd4) begin bad++; $display("FAIL reset_first_fetch: got %h want 4", pcOut); end
    repeat (4) @(negedge clk);
    total++; if (pcOut !== 32'h14) begin bad++; $display("FAIL reset_run_pc: got %h want 14", pcOut); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (pcOut !== 32'd0) begin bad++; $display("FAIL midreset_pc: got %h want 0", pcOut); end
    total++; if (readData1 !== 32'd0) begin bad++; $display("FAIL midreset_rd1: got %h want 0", readData1); end
    total++; if (readData2 !== 32'd0) begin bad++; $display("FAIL midreset_rd2: got %h want 0", readData2); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (pcOut !== 32'd4) begin bad++; $display("FAIL midreset_refetch: got %h want 4", pcOut); end
  endtask

  task automatic test_directed();
    bit halted = 0;
    build_directed();
    load_and_reset();
    for (int cyc = 0; cyc < 40 && !halted; cyc++) begin
      model_eval();
      total++; if (pcOut !== m_pc) begin bad++; $display("FAIL dir_pc: got %h want %h", pcOut, m_pc); end
      total++; if (pcIn !== e_pcin) begin bad++; $display("FAIL dir_pcin @%h: got %h want %h", m_pc, pcIn, e_pcin); end
      total++; if (PcSrc !== e_pcsrc) begin bad++; $display("FAIL dir_pcsrc @%h: got %0d want %0d", m_pc, PcSrc, e_pcsrc); end
      total++; if (RegWre !== e_we) begin bad++; $display("FAIL dir_regwre @%h: got %b want %b", m_pc, RegWre, e_we); end
      if (e_we) begin
        total++; if (WriteReg !== e_wreg || writeData !== e_wdata) begin
          bad++; $display("FAIL dir_wb @%h: got r%0d=%h want r%0d=%h", m_pc, WriteReg, writeData, e_wreg, e_wdata);
        end
      end
      total++; if (mWR !== e_mwr || mRD !== e_mrd) begin bad++; $display("FAIL dir_mem_ctl @%h: got %b%b want %b%b", m_pc, mWR, mRD, e_mwr, e_mrd); end
      total++; if (PCWre !== !e_halt) begin bad++; $display("FAIL dir_pcwre @%h: got %b want %b", m_pc, PCWre, !e_halt); end
      case (m_pc)
        32'h00: begin total++; if (ExtSel !== 1'b1 || ALUSrcB !== 1'b1) begin bad++; $display("FAIL dir_addi_ctl: got %b%b want 11", ExtSel, ALUSrcB); end end
        32'h04: begin total++; if (ExtSel !== 1'b0 || extendResult !== 32'h0000FFFF) begin bad++; $display("FAIL dir_ori_zext: got %b %h want 0 0000ffff", ExtSel, extendResult); end end
        32'h08: begin total++; if (writeData !== 32'h10007 || RegDst !== 1'b1) begin bad++; $display("FAIL dir_add: got %h want 10007", writeData); end end
        32'h0C: begin total++; if (writeData !== 32'hFFF7 || ALUOp !== 3'b001) begin bad++; $display("FAIL dir_sub: got %h want fff7", writeData); end end
        32'h10: begin total++; if (writeData !== 32'd1) begin bad++; $display("FAIL dir_slt: got %h want 1", writeData); end end
        32'h14: begin total++; if (mWR !== 1'b1 || readData2 !== 32'h10007) begin bad++; $display("FAIL dir_sw: got %b %h want 1 10007", mWR, readData2); end end
        32'h18: begin total++; if (DataOut !== 32'h10007 || writeData !== 32'h10007) begin bad++; $display("FAIL dir_lw: got %h want 10007", DataOut); end end
        32'h20: begin total++; if (pcIn !== 32'h2C || PcSrc !== 2'b01) begin bad++; $display("FAIL dir_beq: got %h %b want 2c 01", pcIn, PcSrc); end end
        32'h2C: begin total++; if (pcIn !== 32'h30 || PcSrc !== 2'b00) begin bad++; $display("FAIL dir_bne: got %h %b want 30 00", pcIn, PcSrc); end end
        32'h30: begin total++; if (pcIn !== 32'h40 || PcSrc !== 2'b10) begin bad++; $display("FAIL dir_j: got %h %b want 40 10", pcIn, PcSrc); end end
        default: ;
      endcase
      if (e_halt) halted = 1;
      else begin
        model_commit();
        @(negedge clk);
      end
    end
    total++; if (!halted) begin bad++; $display("FAIL dir_halt_reached: got pc %h want halt at 40", pcOut); end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (pcOut !== 32'h40 || PCWre !== 1'b0) begin bad++; $display("FAIL halt_pc: got %h %b want 40 0", pcOut, PCWre); end
      total++; if (RegWre !== 1'b0 || mWR !== 1'b0) begin bad++; $display("FAIL halt_writes: got %b%b want 00", RegWre, mWR); end
      total++; if (readData1 !== 32'd0 || readData2 !== 32'h10007) begin
        bad++; $display("FAIL halt_regs: got %h %h want 0 10007", readData1, readData2);
      end
    end
  endtask

  task automatic test_random(int runs, int cycles);
    logic [5:0] ops [13];
    ops = '{T_ADD, T_ADDI, T_SUB, T_ORI, T_AND, T_OR, T_SLT, T_SW, T_LW, T_BEQ, T_BNE, T_J, T_UNDEF};
    for (int r = 0; r < runs; r++) begin
      // Prologue clears every RAM word so later loads are predictable.
      prog[0] = enc_i(T_ADDI, 0, 7, 16'd128);
      prog[1] = enc_i(T_ADDI, 7, 7, 16'hFFFC);
      prog[2] = enc_i(T_SW,   7, 0, 16'd0);
      prog[3] = enc_i(T_BNE,  7, 0, 16'hFFFD);
      for (int i = 4; i < 64; i++) begin
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        op = ops[$urandom_range(0, 12)];
        if (op == T_J && $urandom_range(0, 2) != 0) op = T_ADD;
        rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
        case (op)
          T_BEQ, T_BNE: prog[i] = enc_i(op, rs, rt, 16'($urandom_range(0, 8)));
          T_J:          prog[i] = enc_j(op, 26'($urandom_range(4, 63)));
          T_ADD, T_SUB, T_AND, T_OR, T_SLT: prog[i] = enc_r(op, rs, rt, rd);
          default:      prog[i] = enc_i(op, rs, rt, 16'($urandom));
        endcase
      end
      load_and_reset();
      for (int cyc = 0; cyc < cycles; cyc++) begin
        model_eval();
        total++; if (pcOut !== m_pc || IDataOut !== prog[m_pc[7:2]]) begin
          bad++; $display("FAIL rnd_fetch: got %h/%h want %h/%h", pcOut, IDataOut, m_pc, prog[m_pc[7:2]]);
        end
        total++; if (pcIn !== e_pcin || PcSrc !== e_pcsrc) begin
          bad++; $display("FAIL rnd_next @%h: got %h/%0d want %h/%0d", m_pc, pcIn, PcSrc, e_pcin, e_pcsrc);
        end
        total++; if (RegWre !== e_we) begin bad++; $display("FAIL rnd_regwre @%h: got %b want %b", m_pc, RegWre, e_we); end
        if (e_we) begin
          total++; if (WriteReg !== e_wreg || writeData !== e_wdata) begin
            bad++; $display("FAIL rnd_wb @%h: got r%0d=%h want r%0d=%h", m_pc, WriteReg, writeData, e_wreg, e_wdata);
          end
        end
        total++; if (mWR !== e_mwr || mRD !== e_mrd) begin bad++; $display("FAIL rnd_mem_ctl @%h: got %b%b want %b%b", m_pc, mWR, mRD, e_mwr, e_mrd); end
        if (e_mwr) begin
          total++; if (ALUreslut !== e_maddr || readData2 !== e_mdata) begin
            bad++; $display("FAIL rnd_store @%h: got %h<-%h want %h<-%h", m_pc, ALUreslut, readData2, e_maddr, e_mdata);
          end
        end
        model_commit();
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_halt();
    test_random(4, 600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
